// File: rtl/note_sequencer.sv
// Step sequencer: plays a STEPS-deep {note_on, period} pattern as trig gate + oscillator pitch.
// Optional SEQ_ONESHOT_EN adds a oneshot input and done pulse for single-pass playback.
module note_sequencer #(
    parameter int STEPS  = 16,
    parameter int TICK_W = 24,
    localparam int IDX_W = $clog2(STEPS),
    localparam int LEN_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [TICK_W-1:0] step_ticks,
    input  logic [TICK_W-1:0] gate_ticks,
    input  logic [LEN_W-1:0]  length,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [31:0]       wr_period,
    input  logic              wr_note_on,
`ifdef SEQ_ONESHOT_EN
    input  logic              oneshot,
    output logic              done,
`endif
    output logic              trig,
    output logic [31:0]       count_max,
    output logic [IDX_W-1:0]  step_idx,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [32:0]        r_mem [STEPS];

    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  r_step_ticks;
    logic [TICK_W-1:0]  r_gate_ticks;
    logic [LEN_W-1:0]   r_len;
    logic               r_note_on;
    logic [IDX_W-1:0]   r_step_idx;
    logic [31:0]        r_count_max;
    logic               r_trig;
    logic               r_busy;

    logic [TICK_W-1:0]  w_tick_nxt;
    logic [TICK_W-1:0]  w_step_ticks_nxt;
    logic [TICK_W-1:0]  w_gate_ticks_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_note_on_nxt;
    logic [IDX_W-1:0]   w_step_idx_nxt;
    logic [31:0]        w_count_max_nxt;
    logic               w_trig_nxt;
    logic               w_load;

    logic [LEN_W-1:0]   w_len_eff;
    logic               w_last;
    logic               w_tick_end;
    logic [IDX_W-1:0]   w_next_idx;
    logic [IDX_W-1:0]   w_ld_addr;
    logic [32:0]        w_rd;

`ifdef SEQ_ONESHOT_EN
    // r_wait_low blocks a restart until run has been seen low after a one-shot finish
    logic               r_done;
    logic               r_wait_low;
    logic               w_done_nxt;
    logic               w_wait_low_nxt;
`endif

    assign w_len_eff  = (length == '0 || length > LEN_W'(STEPS)) ? LEN_W'(STEPS) : length;
    assign w_last     = ({1'b0, r_step_idx} >= (r_len - LEN_W'(1)));
    assign w_tick_end = (r_tick == r_step_ticks);
    assign w_next_idx = w_last ? '0 : r_step_idx + 1'b1;
    assign w_ld_addr  = (r_state == S_PLAY) ? w_next_idx : '0;
    assign w_rd       = r_mem[w_ld_addr];

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_step_ticks_nxt = r_step_ticks;
        w_gate_ticks_nxt = r_gate_ticks;
        w_len_nxt        = r_len;
        w_note_on_nxt    = r_note_on;
        w_step_idx_nxt   = r_step_idx;
        w_count_max_nxt  = r_count_max;
        w_load           = 1'b0;
`ifdef SEQ_ONESHOT_EN
        w_done_nxt       = 1'b0;
        w_wait_low_nxt   = r_wait_low & run;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef SEQ_ONESHOT_EN
                if (run && !r_wait_low) begin
`else
                if (run) begin
`endif
                    w_state_nxt = S_PLAY;
                    w_load      = 1'b1;
                end
            end
            S_PLAY: begin
                if (!run) begin
                    w_state_nxt    = S_IDLE;
                    w_step_idx_nxt = '0;
                    w_tick_nxt     = '0;
                end else if (w_tick_end) begin
`ifdef SEQ_ONESHOT_EN
                    if (oneshot && w_last) begin
                        w_state_nxt    = S_IDLE;
                        w_step_idx_nxt = '0;
                        w_tick_nxt     = '0;
                        w_done_nxt     = 1'b1;
                        w_wait_low_nxt = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
`else
                    w_load = 1'b1;
`endif
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A rest keeps the previous pitch so the envelope release tail does not jump
        if (w_load) begin
            w_step_idx_nxt   = w_ld_addr;
            w_tick_nxt       = '0;
            w_step_ticks_nxt = step_ticks;
            w_gate_ticks_nxt = gate_ticks;
            w_len_nxt        = w_len_eff;
            w_note_on_nxt    = w_rd[32];
            if (w_rd[32]) begin
                w_count_max_nxt = w_rd[31:0];
            end
        end

        w_trig_nxt = (w_state_nxt == S_PLAY) && w_note_on_nxt && (w_tick_nxt < w_gate_ticks_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_step_ticks <= '0;
            r_gate_ticks <= '0;
            r_len        <= '0;
            r_note_on    <= 1'b0;
            r_step_idx   <= '0;
            r_count_max  <= '0;
            r_trig       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SEQ_ONESHOT_EN
            r_done       <= 1'b0;
            r_wait_low   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_step_ticks <= w_step_ticks_nxt;
            r_gate_ticks <= w_gate_ticks_nxt;
            r_len        <= w_len_nxt;
            r_note_on    <= w_note_on_nxt;
            r_step_idx   <= w_step_idx_nxt;
            r_count_max  <= w_count_max_nxt;
            r_trig       <= w_trig_nxt;
            r_busy       <= (w_state_nxt == S_PLAY);
`ifdef SEQ_ONESHOT_EN
            r_done       <= w_done_nxt;
            r_wait_low   <= w_wait_low_nxt;
`endif
        end
    end

    // Pattern store has no reset; writes are only blocked while rst is held
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            r_mem[wr_addr] <= {wr_note_on, wr_period};
        end
    end

    assign trig      = r_trig;
    assign count_max = r_count_max;
    assign step_idx  = r_step_idx;
    assign busy      = r_busy;
`ifdef SEQ_ONESHOT_EN
    assign done      = r_done;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expected output-change events are queued by the driver and
// popped by a negedge monitor, which also checks the cycle gap between changes.
module tb_note_sequencer;
  localparam int EW = 47;  // {gap[7:0], busy, trig, done, idx[3:0], count_max[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [23:0] step_ticks = '0;
  logic [23:0] gate_ticks = '0;
  logic [4:0]  length = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_period = '0;
  logic        wr_note_on = 1'b0;
  logic        trig;
  logic [31:0] count_max;
  logic [3:0]  step_idx;
  logic        busy;
  logic        done_w;
`ifdef SEQ_ONESHOT_EN
  logic        oneshot = 1'b0;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int gap = 0;
  int ev_num = 0;
  logic mon_en = 1'b0;
  logic [38:0] prev_s;

  note_sequencer #(.STEPS(16), .TICK_W(24)) dut (
    .clk(clk), .rst(rst), .run(run),
    .step_ticks(step_ticks), .gate_ticks(gate_ticks), .length(length),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period), .wr_note_on(wr_note_on),
`ifdef SEQ_ONESHOT_EN
    .oneshot(oneshot), .done(done_w),
`endif
    .trig(trig), .count_max(count_max), .step_idx(step_idx), .busy(busy)
  );

`ifndef SEQ_ONESHOT_EN
  assign done_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_step(input int a, input int p, input logic on);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_period = 32'(p);
    wr_note_on = on;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input int dt, input logic b, input logic t, input int i,
                          input int cm, input logic d);
    exp_q.push_back({8'(dt), b, t, d, 4'(i), 32'(cm)});
  endtask

  // monitor: every change of the output bundle must match the next queued event
  always @(negedge clk) begin
    logic [38:0] cur;
    logic [EW-1:0] e;
    if (mon_en) begin
      cur = {busy, trig, done_w, step_idx, count_max};
      gap = gap + 1;
      if (cur != prev_s) begin
        ev_num = ev_num + 1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_change_%0d: got busy=%0b trig=%0b done=%0b idx=%0d cm=%0d, none expected",
                   ev_num, cur[38], cur[37], cur[36], cur[35:32], cur[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur != e[38:0] || (e[46:39] != 8'd0 && gap != int'(e[46:39]))) begin
            errors = errors + 1;
            $display("FAIL event_%0d: got busy=%0b trig=%0b done=%0b idx=%0d cm=%0d gap=%0d, want busy=%0b trig=%0b done=%0b idx=%0d cm=%0d gap=%0d",
                     ev_num, cur[38], cur[37], cur[36], cur[35:32], cur[31:0], gap,
                     e[38], e[37], e[36], e[35:32], e[31:0], e[46:39]);
          end
        end
        prev_s = cur;
        gap = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    tick(3);
    checks = checks + 1;
    if ({busy, trig, step_idx, count_max} !== 38'd0) begin
      errors = errors + 1;
      $display("FAIL reset_state: got busy=%0b trig=%0b idx=%0d cm=%0d, want all 0",
               busy, trig, step_idx, count_max);
    end
    prev_s = {busy, trig, done_w, step_idx, count_max};
    gap = 0;
    mon_en = 1'b1;
    rst = 1'b0;
    tick(1);

    // basic 4-step loop, then stop at tick 3 of step 2 on the second pass
    write_step(0, 100, 1'b1);
    write_step(1, 200, 1'b1);
    write_step(2, 300, 1'b1);
    write_step(3, 400, 1'b1);
    step_ticks = 24'd9; gate_ticks = 24'd5; length = 5'd4;
    push_exp(0, 1, 1, 0, 100, 0);
    push_exp(5, 1, 0, 0, 100, 0);
    push_exp(5, 1, 1, 1, 200, 0);
    push_exp(5, 1, 0, 1, 200, 0);
    push_exp(5, 1, 1, 2, 300, 0);
    push_exp(5, 1, 0, 2, 300, 0);
    push_exp(5, 1, 1, 3, 400, 0);
    push_exp(5, 1, 0, 3, 400, 0);
    push_exp(5, 1, 1, 0, 100, 0);
    push_exp(5, 1, 0, 0, 100, 0);
    push_exp(5, 1, 1, 1, 200, 0);
    push_exp(5, 1, 0, 1, 200, 0);
    push_exp(5, 1, 1, 2, 300, 0);
    push_exp(4, 0, 0, 0, 300, 0);
    run = 1'b1;
    tick(64);
    run = 1'b0;

    // rest on step 1, restart from 0, mid-step write and same-cycle load/write of step 0
    tick(2);
    push_exp(0, 1, 1, 0, 100, 0);
    push_exp(5, 1, 0, 0, 100, 0);
    push_exp(5, 1, 0, 1, 100, 0);
    push_exp(10, 1, 1, 2, 300, 0);
    push_exp(5, 1, 0, 2, 300, 0);
    push_exp(5, 1, 1, 3, 400, 0);
    push_exp(5, 1, 0, 3, 400, 0);
    push_exp(5, 1, 1, 0, 100, 0);
    push_exp(5, 1, 0, 0, 100, 0);
    push_exp(5, 1, 0, 1, 100, 0);
    push_exp(10, 1, 1, 2, 300, 0);
    push_exp(5, 1, 0, 2, 300, 0);
    push_exp(5, 1, 1, 3, 400, 0);
    push_exp(5, 1, 0, 3, 400, 0);
    push_exp(5, 1, 1, 0, 555, 0);
    push_exp(5, 1, 0, 0, 555, 0);
    push_exp(5, 1, 0, 1, 555, 0);
    push_exp(10, 1, 1, 2, 300, 0);
    push_exp(5, 1, 0, 2, 300, 0);
    push_exp(5, 1, 1, 3, 400, 0);
    push_exp(5, 1, 0, 3, 400, 0);
    push_exp(5, 1, 1, 0, 777, 0);
    push_exp(1, 0, 0, 0, 777, 0);
    write_step(1, 999, 1'b0);
    run = 1'b1;
    tick(42);
    write_step(0, 555, 1'b1);
    tick(37);
    write_step(0, 777, 1'b1);
    tick(40);
    run = 1'b0;

    // legato gate over all 16 steps with length=0
    tick(2);
    write_step(1, 200, 1'b1);
    for (int i = 4; i < 16; i++) write_step(i, 1000 + i, 1'b1);
    step_ticks = 24'd9; gate_ticks = 24'd20; length = 5'd0;
    push_exp(0, 1, 1, 0, 777, 0);
    push_exp(10, 1, 1, 1, 200, 0);
    push_exp(10, 1, 1, 2, 300, 0);
    push_exp(10, 1, 1, 3, 400, 0);
    for (int i = 4; i < 16; i++) push_exp(10, 1, 1, i, 1000 + i, 0);
    push_exp(10, 1, 1, 0, 777, 0);
    push_exp(2, 0, 0, 0, 777, 0);
    run = 1'b1;
    tick(162);
    run = 1'b0;

    // one step per clock, gate_ticks=0 never triggers, length=3
    tick(2);
    step_ticks = 24'd0; gate_ticks = 24'd0; length = 5'd3;
    push_exp(0, 1, 0, 0, 777, 0);
    push_exp(1, 1, 0, 1, 200, 0);
    push_exp(1, 1, 0, 2, 300, 0);
    push_exp(1, 1, 0, 0, 777, 0);
    push_exp(1, 0, 0, 0, 777, 0);
    run = 1'b1;
    tick(4);
    run = 1'b0;

    // reset mid-step with run and a write held high; the write must be ignored
    tick(2);
    step_ticks = 24'd9; gate_ticks = 24'd5; length = 5'd4;
    push_exp(0, 1, 1, 0, 777, 0);
    push_exp(3, 0, 0, 0, 0, 0);
    push_exp(2, 1, 1, 0, 777, 0);
    push_exp(2, 0, 0, 0, 777, 0);
    run = 1'b1;
    tick(3);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_period = 32'd12345; wr_note_on = 1'b1;
    tick(2);
    rst = 1'b0;
    wr_en = 1'b0;
    tick(2);
    run = 1'b0;

`ifdef SEQ_ONESHOT_EN
    // single pass of 2 steps, no restart while run stays high
    tick(2);
    oneshot = 1'b1;
    step_ticks = 24'd3; gate_ticks = 24'd2; length = 5'd2;
    push_exp(0, 1, 1, 0, 777, 0);
    push_exp(2, 1, 0, 0, 777, 0);
    push_exp(2, 1, 1, 1, 200, 0);
    push_exp(2, 1, 0, 1, 200, 0);
    push_exp(2, 0, 0, 0, 200, 1);
    push_exp(1, 0, 0, 0, 200, 0);
    push_exp(11, 1, 1, 0, 777, 0);
    push_exp(1, 0, 0, 0, 777, 0);
    run = 1'b1;
    tick(19);
    run = 1'b0;
    tick(1);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    oneshot = 1'b0;
`endif

    tick(5);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL pending_events: got %0d events never seen, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 16, pattern depth; a power of two.
REQ-002 SHALL have parameter TICK_W, default 24, width of the tick timing inputs.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port run, input, 1: level high = play, low = stop.
REQ-006 SHALL have port step_ticks, input, TICK_W: step duration is step_ticks+1 clocks.
REQ-007 SHALL have port gate_ticks, input, TICK_W: trig high time in clocks per sounding step.
REQ-008 SHALL have port length, input, log2(STEPS)+1: active steps; 0 or >STEPS means STEPS.
REQ-009 SHALL have port wr_en, input, 1, pattern write strobe.
REQ-010 SHALL have port wr_addr, input, log2(STEPS), pattern write address.
REQ-011 SHALL have port wr_period, input, 32, oscillator count_max for the step.
REQ-012 SHALL have port wr_note_on, input, 1: 1 = sounding step, 0 = rest.
REQ-013 SHALL have port trig, output, 1, gate to the ADSR trig input.
REQ-014 SHALL have port count_max, output, 32, pitch to the oscillator.
REQ-015 SHALL have port step_idx, output, log2(STEPS), current step index.
REQ-016 SHALL have port busy, output, 1, high while in state PLAY.

Function
REQ-017 SHALL hold a STEPS x 33-bit pattern store {note_on, period}, written on the clk edge when wr_en=1, in any state.
REQ-018 SHALL return old data when the store is read and written at the same address in the same cycle; the new data takes effect the next time that step is loaded.
REQ-019 SHALL implement two states, IDLE and PLAY; all outputs are registered.
REQ-020 IDLE with run=1 at edge N SHALL enter PLAY at N+1 with step_idx=0, tick=0, and step 0 loaded.
REQ-021 Loading a step SHALL latch step_ticks, gate_ticks and length for that step's duration.
REQ-022 Loading a step SHALL update count_max to the step's period only if note_on=1; on a rest, count_max SHALL hold its value so the release tail keeps its pitch.
REQ-023 In PLAY, the tick counter SHALL count 0..latched step_ticks.
REQ-024 trig SHALL be 1 exactly when note_on=1 and tick < latched gate_ticks.
REQ-025 gate_ticks=0 SHALL give no trig pulse.
REQ-026 gate_ticks > step_ticks SHALL keep trig high for the whole step; consecutive sounding steps then hold trig continuously high (legato, no retrigger).
REQ-027 At tick=step_ticks, the next edge SHALL load step (step_idx >= len-1 ? 0 : step_idx+1), with len the latched length.
REQ-028 run=0 in PLAY SHALL return to IDLE on the next edge, aborting mid-step, with trig=0 and step_idx=0; count_max SHALL hold.
REQ-029 run re-asserted SHALL always restart at step 0.
REQ-030 step_ticks=0 SHALL advance one step per clock.

Reset
REQ-031 rst=1 SHALL force IDLE, trig=0, count_max=0, step_idx=0, busy=0 and tick=0, taking priority over run and wr_en.
REQ-032 Pattern store contents SHALL be unaffected by rst, and rst SHALL NOT be required to initialise them.

Configuration
REQ-033 Macro SEQ_ONESHOT_EN, when defined, SHALL add input oneshot (1) and output done (1).
REQ-034 With SEQ_ONESHOT_EN defined and oneshot=1, completion of the last active step SHALL enter IDLE instead of wrapping, with done=1 for exactly one cycle.
REQ-035 After a one-shot completion, a new run low-to-high transition SHALL be required to restart.
REQ-036 Without SEQ_ONESHOT_EN, ports oneshot and done SHALL be absent and the sequence SHALL always loop.

Verification
REQ-037 Load steps 0..3 with periods 100, 200, 300, 400 (all note_on), length=4, step_ticks=9, gate_ticks=5, then run=1 -> count_max 100, 200, 300, 400, 100 every 10 clocks; trig high 5 clocks of each 10.
REQ-038 Step 1 is a rest -> during step 1 count_max stays 100 and trig stays 0.
REQ-039 run=0 at tick 3 of step 2 -> next cycle trig=0, busy=0, step_idx=0, count_max=300; run=1 again -> restarts at step 0.
REQ-040 Write step 0 period 555 while step 0 is playing -> current step keeps the old value; the next pass outputs 555.
REQ-041 gate_ticks=20, step_ticks=9 -> trig constant 1 across all sounding steps; length=0 -> wraps after step 15.
REQ-042 SEQ_ONESHOT_EN with oneshot=1, length=2 -> after 2 steps busy=0, done pulses 1 cycle, run held high does not restart.
